cdma_frame_sequencer: RTL and testbench

- Sequences one CDMA frame across the shared channel: accepts words from N_SRC encoder lanes and drives the common chip counter and rotate_code.
- Generates the counter and rotate_code that every encoder and decoder in the crossbar consumes.
- Signals when decoder outputs hold a complete despread word, with output backpressure.
- Sits between the source-side valid/ready interfaces and the encoder/decoder array.

---
 rtl/cdma_frame_sequencer.sv | 148 ++++++++++++++
 tb/tb_cdma_frame_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/cdma_frame_sequencer.sv
// rtl/cdma_frame_sequencer.sv - CDMA frame sequencer: launches frames, drives chip counter/rotate_code, flags decoded words
//
// Purpose:
//   Accepts one word per participating source lane at frame launch, then steps
//   the shared chip counter through 0..CODE_LEN-1 with rotate_code asserted.
//   After the last chip the decoded word is presented with dec_valid until
//   dec_ready. A new frame may launch in the same cycle as that transfer.
//
// Optional feature (macro CDMA_SEQ_PERF_EN):
//   Adds saturating frame_cnt / stall_cnt performance counters.
//
// Ports:
//   clk          clock
//   rst          asynchronous reset, active-low
//   src_valid    [N_SRC]  lane has a word to send
//   src_ready    [N_SRC]  one-cycle accept pulse per lane at launch
//   enc_load     encoders capture lane data of frame_mask lanes
//   frame_mask   [N_SRC]  lanes participating in the current frame
//   counter      [CNT_W]  chip index; all-ones means idle / code reload
//   rotate_code  advance codes by one chip
//   dec_valid    decoders hold a complete word
//   dec_mask     [N_SRC]  lanes valid in the decoded word
//   dec_ready    downstream accepts decoded word
//   busy         sequencer is in RUN or DONE
//   frame_cnt    [32]     (perf) completed frame transfers, saturating
//   stall_cnt    [32]     (perf) DONE cycles with dec_ready low, saturating

module cdma_frame_sequencer #(
  parameter int N_SRC    = 4,
  parameter int CODE_LEN = 8,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] src_valid,
  output logic [N_SRC-1:0] src_ready,
  output logic             enc_load,
  output logic [N_SRC-1:0] frame_mask,
  output logic [CNT_W-1:0] counter,
  output logic             rotate_code,
  output logic             dec_valid,
  output logic [N_SRC-1:0] dec_mask,
  input  logic             dec_ready,
  output logic             busy
`ifdef CDMA_SEQ_PERF_EN
  ,
  output logic [31:0]      frame_cnt,
  output logic [31:0]      stall_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // All-ones is reserved as the "no chip" value, so it can never be a chip index.
  localparam logic [CNT_W-1:0] CNT_IDLE = '1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CODE_LEN - 1);

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt_n;
  logic [N_SRC-1:0]   mask_n;
  logic               launch;
  logic               rotate_c;
  logic               done_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      counter    <= CNT_IDLE;
      frame_mask <= '0;
    end else begin
      state      <= state_n;
      counter    <= cnt_n;
      frame_mask <= mask_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = counter;
    mask_n   = frame_mask;
    launch   = 1'b0;
    rotate_c = 1'b0;
    done_c   = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = CNT_IDLE;
        // Gated by rst so the combinational accept stays quiet while reset is held.
        if (rst && (|src_valid)) launch = 1'b1;
      end
      RUN: begin
        rotate_c = 1'b1;
        if (counter == CNT_LAST) begin
          state_n = DONE;
          cnt_n   = CNT_IDLE;
        end else begin
          cnt_n = counter + CNT_W'(1);
        end
      end
      DONE: begin
        done_c = 1'b1;
        cnt_n  = CNT_IDLE;
        if (dec_ready) begin
          if (|src_valid) begin
            launch = 1'b1;
          end else begin
            state_n = IDLE;
            mask_n  = '0;
          end
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = CNT_IDLE;
        mask_n  = '0;
      end
    endcase
    // Launch is shared by IDLE and the back-to-back DONE transfer.
    if (launch) begin
      state_n = RUN;
      cnt_n   = '0;
      mask_n  = src_valid;
    end
  end

  assign src_ready   = launch ? src_valid : '0;
  assign enc_load    = launch;
  assign rotate_code = rotate_c;
  assign dec_valid   = done_c;
  assign dec_mask    = done_c ? frame_mask : '0;
  assign busy        = (state != IDLE);

`ifdef CDMA_SEQ_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (done_c && dec_ready && (frame_cnt != '1)) frame_cnt <= frame_cnt + 32'd1;
      if (done_c && !dec_ready && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cdma_frame_sequencer.sv
// tb/tb_cdma_frame_sequencer.sv - randomized self-checking bench for cdma_frame_sequencer

module tb_cdma_frame_sequencer;

  localparam int N_SRC    = 4;
  localparam int CODE_LEN = 8;
  localparam int CNT_W    = 4;

  logic             clk;
  logic             rst;
  logic [N_SRC-1:0] src_valid;
  logic [N_SRC-1:0] src_ready;
  logic             enc_load;
  logic [N_SRC-1:0] frame_mask;
  logic [CNT_W-1:0] counter;
  logic             rotate_code;
  logic             dec_valid;
  logic [N_SRC-1:0] dec_mask;
  logic             dec_ready;
  logic             busy;
`ifdef CDMA_SEQ_PERF_EN
  logic [31:0]      frame_cnt;
  logic [31:0]      stall_cnt;
`endif

  cdma_frame_sequencer #(
    .N_SRC(N_SRC),
    .CODE_LEN(CODE_LEN),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .src_valid(src_valid),
    .src_ready(src_ready),
    .enc_load(enc_load),
    .frame_mask(frame_mask),
    .counter(counter),
    .rotate_code(rotate_code),
    .dec_valid(dec_valid),
    .dec_mask(dec_mask),
    .dec_ready(dec_ready),
    .busy(busy)
`ifdef CDMA_SEQ_PERF_EN
    ,
    .frame_cnt(frame_cnt),
    .stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: age counts cycles since launch.
  // 0 = no frame, 1..CODE_LEN = chip (age-1) being sent, CODE_LEN+1 = word ready.
  int               age;
  logic [N_SRC-1:0] m_mask;
  longint           m_frames;
  longint           m_stalls;

  task automatic model_reset();
    age      = 0;
    m_mask   = '0;
    m_frames = 0;
    m_stalls = 0;
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_counter"}, 32'(counter), 32'hF);
    check({pfx, "_rotate"}, 32'(rotate_code), 32'd0);
    check({pfx, "_enc_load"}, 32'(enc_load), 32'd0);
    check({pfx, "_src_ready"}, 32'(src_ready), 32'd0);
    check({pfx, "_frame_mask"}, 32'(frame_mask), 32'd0);
    check({pfx, "_dec_mask"}, 32'(dec_mask), 32'd0);
    check({pfx, "_dec_valid"}, 32'(dec_valid), 32'd0);
    check({pfx, "_busy"}, 32'(busy), 32'd0);
`ifdef CDMA_SEQ_PERF_EN
    check({pfx, "_frame_cnt"}, frame_cnt, 32'd0);
    check({pfx, "_stall_cnt"}, stall_cnt, 32'd0);
`endif
  endtask

  // One clock: drive inputs after the falling edge, compare, then advance the model.
  task automatic step(input logic [N_SRC-1:0] sv, input logic dr);
    logic             running, ready_word, launch;
    logic [CNT_W-1:0] e_cnt;
    @(negedge clk);
    src_valid = sv;
    dec_ready = dr;
    #1;
    running    = (age >= 1) && (age <= CODE_LEN);
    ready_word = (age == CODE_LEN + 1);
    launch     = ((age == 0) || (ready_word && dr)) && (sv != '0);
    e_cnt      = running ? CNT_W'(age - 1) : 4'hF;
    check("counter", 32'(counter), 32'(e_cnt));
    check("rotate_code", 32'(rotate_code), 32'(running));
    check("enc_load", 32'(enc_load), 32'(launch));
    check("src_ready", 32'(src_ready), launch ? 32'(sv) : 32'd0);
    check("frame_mask", 32'(frame_mask), 32'(m_mask));
    check("dec_valid", 32'(dec_valid), 32'(ready_word));
    check("dec_mask", 32'(dec_mask), ready_word ? 32'(m_mask) : 32'd0);
    check("busy", 32'(busy), 32'(age != 0));
`ifdef CDMA_SEQ_PERF_EN
    check("frame_cnt", frame_cnt, 32'(m_frames));
    check("stall_cnt", stall_cnt, 32'(m_stalls));
`endif
    @(posedge clk);
    if (ready_word) begin
      if (dr) m_frames++;
      else    m_stalls++;
    end
    if (launch) begin
      age    = 1;
      m_mask = sv;
    end else if (running) begin
      age = age + 1;
    end else if (ready_word && dr) begin
      age    = 0;
      m_mask = '0;
    end
  endtask

  initial begin
    logic hit;
    logic [N_SRC-1:0] sv;
    longint stalls_before;

    src_valid = '0;
    dec_ready = 1'b0;
    rst       = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check_reset_values("por");
    @(negedge clk);
    rst = 1'b1;

    // Single lane.
    step(4'b0001, 1'b1);
    for (int i = 0; i < CODE_LEN + 3; i++) step(4'b0000, 1'b1);

    // Multi-lane with lane 2 raised mid-frame, taken at the next launch.
    step(4'b1011, 1'b1);
    for (int i = 0; i < CODE_LEN; i++) step(4'b1111, 1'b1);
    step(4'b0100, 1'b1);
    for (int i = 0; i < CODE_LEN + 3; i++) step(4'b0000, 1'b1);

    // Back-to-back frames.
    for (int i = 0; i < 3 * (CODE_LEN + 1) + 1; i++) step(4'b1111, 1'b1);
    for (int i = 0; i < CODE_LEN + 2; i++) step(4'b0000, 1'b1);

    // Backpressure: five stall cycles in DONE.
    step(4'b1111, 1'b0);
    for (int i = 0; i < CODE_LEN; i++) step(4'b0000, 1'b0);
    stalls_before = m_stalls;
    for (int i = 0; i < 5; i++) step(4'b1111, 1'b0);
    check("bp_stall_cycles", 32'(m_stalls - stalls_before), 32'd5);
    step(4'b1111, 1'b1);
    for (int i = 0; i < CODE_LEN + 3; i++) step(4'b0000, 1'b1);

    // Idle for 20 cycles.
    for (int i = 0; i < 20; i++) step(4'b0000, 1'($urandom_range(0, 1)));

    // Reset while counter == 3.
    step(4'b0110, 1'b1);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      #1;
      if (counter == 4'd3) hit = 1'b1;
      else step(4'b0000, 1'b1);
    end
    check("reach_cnt3", 32'(hit), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check_reset_values("midrst");
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < CODE_LEN + 4; i++) step(4'b0000, 1'b1);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      sv = ($urandom_range(0, 9) < 4) ? 4'b0000 : 4'($urandom);
      step(sv, ($urandom_range(0, 9) < 7));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
